// File: rtl/seg7_multi_driver.sv
// Multi-digit 7-segment driver: shadowed hex value + blank mask, registered active-low
// segment outputs, whole-display blinking. Define SEG7_LZ_SUPPRESS_EN for leading-zero suppression.
module seg7_multi_driver #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   leds
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    phase_t                phase_reg, phase_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [4*DIGITS-1:0]   value_reg;
    logic [DIGITS-1:0]     mask_reg;
    logic [7*DIGITS-1:0]   leds_reg, leds_next;
    logic [DIGITS-1:0]     dark;
    logic                  blink_dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg <= PH_ON;
            cnt_reg   <= '0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Disabled blinking parks the counter so re-enabling always starts a full ON half-period.
    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        if (!blink_en) begin
            cnt_next   = '0;
            phase_next = PH_ON;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next   = '0;
            phase_next = (phase_reg == PH_ON) ? PH_OFF : PH_ON;
        end else begin
            cnt_next   = cnt_reg + CW'(1);
        end
    end

    // blink_en gates the OFF phase directly so dropping it restores the display on the next edge.
    assign blink_dark = blink_en && (phase_reg == PH_OFF);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
`ifdef SEG7_LZ_SUPPRESS_EN
            if (gi == 0) begin : g_lsd
                assign dark[gi] = mask_reg[gi] || blink_dark;
            end else begin : g_upper
                assign dark[gi] = mask_reg[gi] || blink_dark
                                  || (value_reg[4*DIGITS-1:4*gi] == '0);
            end
`else
            assign dark[gi] = mask_reg[gi] || blink_dark;
`endif
            assign leds_next[7*gi +: 7] = dark[gi] ? 7'b1111111
                                                   : seg_decode(value_reg[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
            mask_reg  <= '1;
            leds_reg  <= '1;
        end else begin
            if (load) begin
                value_reg <= value;
                mask_reg  <= blank_mask;
            end
            leds_reg <= leds_next;
        end
    end

    assign leds = leds_reg;

endmodule

// File: doc/seg7_multi_driver.md
SEG7_MULTI_DRIVER -- requirements
Module: seg7_multi_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 6, giving the number of 7-segment digits driven (legal range 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, giving clock cycles per blink half-period (legal range >= 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port load, input, 1 bit: capture strobe for value and blank_mask.
REQ-006 SHALL have port value, input, 4*DIGITS bits: hex nibble per digit; digit i uses bits [4i+3:4i]; digit 0 is rightmost.
REQ-007 SHALL have port blank_mask, input, DIGITS bits: bit i = 1 forces digit i dark.
REQ-008 SHALL have port blink_en, input, 1 bit: level enabling whole-display blinking.
REQ-009 SHALL have port leds, output, 7*DIGITS bits: active-low segments {g,f,e,d,c,b,a}; digit i uses bits [7i+6:7i].

Function
REQ-010 SHALL hold value and blank_mask in shadow registers; load=1 at an edge captures both, and load=0 holds them.
REQ-011 SHALL register leds: leds reflects the shadow contents and blink phase exactly one cycle after any change to either.
REQ-012 SHALL decode each nibble as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-013 SHALL decode 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-014 SHALL drive a blanked digit as 1111111.
REQ-015 SHALL run a blink counter from 0 to BLINK_DIV-1; at terminal count the counter wraps to 0 and the phase bit toggles.
REQ-016 SHALL use phase states ON and OFF, entering ON at reset; with blink_en=1, state OFF blanks all digits and state ON displays normally.
REQ-017 SHALL, with blink_en=0, hold the counter at 0 and the phase at ON; the display is steady.
REQ-018 SHALL, when blink_en rises, start counting from 0 in state ON, so the first dark period begins BLINK_DIV cycles later.
REQ-019 SHALL capture the new data when load and terminal count occur in the same cycle; the next leds value SHALL use both the new data and the toggled phase.
REQ-020 SHALL make load=1 held across consecutive cycles track value every cycle.

Reset
REQ-021 SHALL, while reset=0, asynchronously clear the shadow value to 0, set blank_mask to all ones, clear the counter to 0, set the phase to ON, and drive leds to all ones.
REQ-022 SHALL make reset asserted mid-blink or mid-load take priority; after release, the first edge behaves as though coming out of reset.
REQ-023 SHALL show all digits dark after reset until the first load.

Configuration
REQ-024 SHALL support the macro SEG7_LZ_SUPPRESS_EN, which enables leading-zero suppression.
REQ-025 SHALL, when SEG7_LZ_SUPPRESS_EN is defined, blank every zero digit above the most significant nonzero digit; digit 0 is never suppressed, and suppression is ORed with blank_mask.
REQ-026 SHALL, when SEG7_LZ_SUPPRESS_EN is undefined, display zero digits normally; no suppression logic is synthesised.

Verification
REQ-027 SHALL cover reset: DIGITS=6 -> leds all ones during reset and after release; load value=0x012345, mask=0 -> one cycle later digits 5..0 show 0,1,2,3,4,5 (digit 5 = 1000000 without the macro).
REQ-028 SHALL cover decode: sweep every nibble 0..F on digit 0 with load pulses -> each leds[6:0] matches REQ-012/013 one cycle after load.
REQ-029 SHALL cover blink: BLINK_DIV=4, blink_en=1 -> leds alternates all ones / data, 4 cycles each; dropping blink_en restores steady data within 1 cycle.
REQ-030 SHALL cover simultaneous events: load coincident with terminal count -> next leds shows the new data blanked (phase OFF), or the new data shown (phase ON).
REQ-031 SHALL cover leading-zero suppression: with SEG7_LZ_SUPPRESS_EN, load 0x000070 -> digits 5..2 = 1111111, digit 1 = 1111000, digit 0 = 1000000; load 0 -> only digit 0 lit as 0.
REQ-032 SHALL cover async reset: assert reset between edges during blink OFF -> leds goes to all ones immediately, without waiting for clk.
